// File: rtl/x_pulse_gen_pkg.sv
// Shared definitions for the X pulse generator: sequencer state encoding,
// target level encoding and the level helper functions used by the shadow model.
package x_pulse_gen_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PULSE = 3'd1,
    ST_GAP   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Level of the target saturating FSM.
  typedef logic [1:0] lvl_t;

  localparam lvl_t LVL0 = 2'd0;
  localparam lvl_t LVL1 = 2'd1;
  localparam lvl_t LVL2 = 2'd2;
  localparam lvl_t LVL3 = 2'd3;

  // One X pulse moves the target up one level; level 3 holds.
  function automatic lvl_t lvl_sat_inc(input lvl_t lvl);
    lvl_t nxt;
    if (lvl == LVL3) begin
      nxt = LVL3;
    end else begin
      nxt = lvl + 2'd1;
    end
    return nxt;
  endfunction

  // Expected Z1 of the target: asserted at the two middle levels.
  function automatic logic lvl_z1(input lvl_t lvl);
    logic z;
    case (lvl)
      LVL1:    z = 1'b1;
      LVL2:    z = 1'b1;
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  // Expected Z2 of the target: asserted only at the top level.
  function automatic logic lvl_z2(input lvl_t lvl);
    logic z;
    if (lvl == LVL3) begin
      z = 1'b1;
    end else begin
      z = 1'b0;
    end
    return z;
  endfunction

endpackage

// File: rtl/x_pulse_gen_lvl_model.sv
// Shadow model of the target level FSM: follows every X pulse with a
// saturating increment and compares the target's Z1/Z2 against the model.
// The target updates on the same edge as this model, so no alignment delay
// is applied to the comparison.
module x_lvl_model
  import x_pulse_gen_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,      // registered X as seen by the target
  input  logic       check_en,  // compare only while the generator is busy
  input  logic       z1,
  input  logic       z2,
  output logic [1:0] exp_lvl,
  output logic       mismatch
);

  lvl_t lvl_q;
  lvl_t lvl_d;
  logic z1_exp_s;
  logic z2_exp_s;

  // Next shadow level: advance on each pulse the target sees.
  always_comb begin
    lvl_d = lvl_q;
    if (step) begin
      lvl_d = lvl_sat_inc(lvl_q);
    end else begin
      lvl_d = lvl_q;
    end
  end

  // Shadow level register; cleared together with the target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q <= LVL0;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  // Compare the target outputs against the levels they should decode to.
  always_comb begin
    z1_exp_s = lvl_z1(lvl_q);
    z2_exp_s = lvl_z2(lvl_q);
    if (check_en) begin
      mismatch = (z1 != z1_exp_s) || (z2 != z2_exp_s);
    end else begin
      mismatch = 1'b0;
    end
  end

  assign exp_lvl = lvl_q;

endmodule

// File: rtl/x_pulse_gen.sv
// X pulse generator: emits a requested number of one-cycle X pulses separated
// by a programmable gap, shadows the target level and flags any Z1/Z2
// disagreement while busy. All outputs are flops loaded from the next state.
module x_pulse_gen
  import x_pulse_gen_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] pulse_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic             X,
  input  logic             Z1,
  input  logic             Z2,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       exp_lvl
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_d;
  logic [GAP_W-1:0] gap_lat_q;
  logic [GAP_W-1:0] gap_lat_d;
  logic [GAP_W-1:0] gcnt_q;
  logic [GAP_W-1:0] gcnt_d;

  logic             x_q;
  logic             x_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic             err_q;
  logic             err_d;

  logic             accept_s;
  logic             mismatch_s;
  logic [1:0]       exp_lvl_s;

  // A start only counts while idle; everywhere else it is ignored.
  assign accept_s = (state_q == ST_IDLE) && start;

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= CNT_ZERO;
      gap_lat_q <= GAP_ZERO;
      gcnt_q    <= GAP_ZERO;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      gap_lat_q <= gap_lat_d;
      gcnt_q    <= gcnt_d;
    end
  end

  // Next-state and counter logic of the pulse sequencer.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    gap_lat_d = gap_lat_q;
    gcnt_d    = gcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d     = pulse_cnt;
          gap_lat_d = gap;
          gcnt_d    = GAP_ZERO;
          if (pulse_cnt != CNT_ZERO) begin
            state_d = ST_PULSE;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PULSE: begin
        rem_d = rem_q - CNT_ONE;
        if (rem_q == CNT_ONE) begin
          state_d = ST_CHECK;
        end else if (gap_lat_q == GAP_ZERO) begin
          state_d = ST_PULSE;
        end else begin
          state_d = ST_GAP;
          gcnt_d  = gap_lat_q;
        end
      end
      ST_GAP: begin
        gcnt_d = gcnt_q - GAP_ONE;
        if (gcnt_q == GAP_ONE) begin
          state_d = ST_PULSE;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_CHECK: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        rem_d     = CNT_ZERO;
        gap_lat_d = GAP_ZERO;
        gcnt_d    = GAP_ZERO;
      end
    endcase
  end

  // Output decode from the upcoming state, so the flops line up with it.
  always_comb begin
    x_d    = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_PULSE: begin
        x_d    = 1'b1;
        busy_d = 1'b1;
      end
      ST_GAP: begin
        busy_d = 1'b1;
      end
      ST_CHECK: begin
        busy_d = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        x_d    = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Sticky mismatch flag: cleared by an accepted start, set by any mismatch.
  always_comb begin
    err_d = err_q;
    if (accept_s) begin
      err_d = 1'b0;
    end else if (mismatch_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // Shadow of the target level plus the Z1/Z2 comparator.
  x_lvl_model u_lvl_model (
    .clk      (clk),
    .reset    (reset),
    .step     (x_q),
    .check_en (busy_q),
    .z1       (Z1),
    .z2       (Z2),
    .exp_lvl  (exp_lvl_s),
    .mismatch (mismatch_s)
  );

  assign X       = x_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign exp_lvl = exp_lvl_s;

endmodule

// File: tb/tb_x_pulse_gen.sv
// Self-checking bench for x_pulse_gen. A behavioural saturating-level target
// sits on X/Z1/Z2 (Z1 can be forced low to act as a faulty target), and each
// request is checked cycle by cycle against a pulse schedule computed from
// the request's count and gap.
module tb_x_pulse_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pulse_cnt;
  logic [3:0] gap;
  logic       X;
  logic       Z1;
  logic       Z2;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] exp_lvl;

  logic [1:0] tgt_lvl;
  logic       stub_z1_low;

  int n_cmp = 0;
  int n_bad = 0;
  int model_lvl = 0;

  always #5 clk = ~clk;

  x_pulse_gen #(.CNT_W(8), .GAP_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pulse_cnt (pulse_cnt),
    .gap       (gap),
    .X         (X),
    .Z1        (Z1),
    .Z2        (Z2),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .exp_lvl   (exp_lvl)
  );

  // Target level FSM, reset together with the generator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tgt_lvl <= 2'd0;
    else if (X && tgt_lvl != 2'd3) tgt_lvl <= tgt_lvl + 2'd1;
  end

  assign Z1 = stub_z1_low ? 1'b0 : (tgt_lvl == 2'd1 || tgt_lvl == 2'd2);
  assign Z2 = (tgt_lvl == 2'd3);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0;
    stub_z1_low = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_lvl = 0;
  endtask

  // One request of n pulses with gap g; stub forces Z1 low, noisy toggles
  // start and scrambles pulse_cnt/gap while the request is running.
  task automatic run_req(input int n, input int g, input bit stub, input bit noisy);
    int  len;
    int  span;
    int  cnt;
    int  lvl;
    bit  ex;
    bit  eb;
    bit  e_err;
    @(negedge clk);
    stub_z1_low = stub;
    start = 1'b1;
    pulse_cnt = 8'(n);
    gap = 4'(g);
    @(posedge clk);
    span  = (n == 0) ? 0 : n + (n - 1) * g;
    len   = (n == 0) ? 1 : span + 2;
    cnt   = 0;
    e_err = 1'b0;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      ex  = (k <= span) && (((k - 1) % (g + 1)) == 0);
      eb  = (n != 0) && (k < len);
      lvl = model_lvl + cnt;
      if (lvl > 3) lvl = 3;
      check_val("x", X, 32'(ex));
      check_val("busy", busy, 32'(eb));
      check_val("done", done, 32'(k == len));
      check_val("exp_lvl", exp_lvl, 32'(lvl));
      check_val("err", err, 32'(e_err));
      if (eb && stub && (lvl == 1 || lvl == 2)) e_err = 1'b1;
      if (ex) cnt++;
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        pulse_cnt = 8'($urandom);
        gap = 4'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    model_lvl = model_lvl + n;
    if (model_lvl > 3) model_lvl = 3;
    @(negedge clk);
    check_val("idle_x", X, 32'd0);
    check_val("idle_busy", busy, 32'd0);
    check_val("idle_done", done, 32'd0);
    check_val("idle_exp_lvl", exp_lvl, 32'(model_lvl));
    check_val("idle_err", err, 32'(e_err));
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pulse_cnt = 8'd0;
    gap = 4'd0;
    stub_z1_low = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_x", X, 32'd0);
    check_val("rst_busy", busy, 32'd0);
    check_val("rst_done", done, 32'd0);
    check_val("rst_err", err, 32'd0);
    check_val("rst_exp_lvl", exp_lvl, 32'd0);
    reset = 1'b0;

    // Three pulses, gap 2: pulses in cycles 1,4,7, done in 9.
    run_req(3, 2, 1'b0, 1'b0);
    check_val("z2_top", Z2, 32'd1);

    // Back-to-back pulses saturating from level 0.
    do_reset();
    run_req(5, 0, 1'b0, 1'b0);

    // Zero-length request: only done, level untouched.
    run_req(0, 1, 1'b0, 1'b0);

    // Faulty target with Z1 stuck low; err sticks, then clears on new start.
    do_reset();
    run_req(1, 0, 1'b1, 1'b0);
    run_req(2, 1, 1'b0, 1'b0);

    // Start hammered during a run: no restart, exactly one done.
    do_reset();
    run_req(4, 3, 1'b0, 1'b1);

    // Reset in the middle of a gap aborts everything.
    do_reset();
    @(negedge clk);
    start = 1'b1;
    pulse_cnt = 8'd4;
    gap = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_val("mid_busy", busy, 32'd1);
    check_val("mid_lvl", exp_lvl, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_val("abort_x", X, 32'd0);
    check_val("abort_busy", busy, 32'd0);
    check_val("abort_done", done, 32'd0);
    check_val("abort_err", err, 32'd0);
    check_val("abort_exp_lvl", exp_lvl, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_lvl = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_val("abort_no_done", done, 32'd0);
      check_val("abort_no_x", X, 32'd0);
    end
    run_req(1, 0, 1'b0, 1'b0);
    check_val("after_abort_z1", Z1, 32'd1);

    // Randomized requests against the schedule model.
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 5) == 0) do_reset();
      run_req(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
